// File: rtl/ysyx_25040101_ifu.sv
// ysyx_25040101_ifu - instruction fetch unit.
//
// Holds the PC and fetches one 32-bit instruction at a time from instruction
// memory. At most one memory request is outstanding. A redirect from execute
// overrides everything. A fetch that is in flight when a redirect arrives is
// marked stale (r_kill) and its response is dropped when it returns.
//
// Ports:
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   o_imem_req_valid/addr   fetch request (addr is always the current PC)
//   i_imem_req_ready        memory accepts the request this cycle
//   i_imem_resp_valid/data  fetched word, with access fault flag i_imem_resp_err
//   i_redirect_valid/pc     new PC from execute (bits [1:0] forced to 00)
//   o_out_valid/i_out_ready instruction handshake towards decode
//   o_out_inst/pc/fault     instruction word, its PC, fetch access fault
module ysyx_25040101_ifu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic        o_imem_req_valid,
    input  logic        i_imem_req_ready,
    output logic [31:0] o_imem_req_addr,
    input  logic        i_imem_resp_valid,
    input  logic [31:0] i_imem_resp_data,
    input  logic        i_imem_resp_err,
    input  logic        i_redirect_valid,
    input  logic [31:0] i_redirect_pc,
    output logic        o_out_valid,
    input  logic        i_out_ready,
    output logic [31:0] o_out_inst,
    output logic [31:0] o_out_pc,
    output logic        o_out_fault
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic        r_kill;
    logic [31:0] r_inst;
    logic        r_fault;
    logic [31:0] w_target;

    // Redirect targets are word aligned; the low bits are simply masked off.
    assign w_target = i_redirect_pc & ~32'h3;

    // Gated by reset so no request escapes while the core is held in reset;
    // a redirect this cycle means the current PC is already stale.
    assign o_imem_req_valid = i_rst_n && (r_state == S_REQ) && !i_redirect_valid;
    assign o_imem_req_addr  = r_pc;

    assign o_out_valid = (r_state == S_OUT);
    assign o_out_pc    = r_pc;
    assign o_out_inst  = r_inst;
    assign o_out_fault = r_fault;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_REQ;
            r_pc    <= RESET_PC;
            r_kill  <= 1'b0;
            r_inst  <= 32'h0;
            r_fault <= 1'b0;
        end else begin
            case (r_state)
                S_REQ: begin
                    if (i_redirect_valid) begin
                        r_pc <= w_target;
                    end else if (i_imem_req_ready) begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (i_redirect_valid) begin
                        r_pc <= w_target;
                        // Response arriving with the redirect is dropped on
                        // the spot; otherwise remember to drop it later.
                        if (i_imem_resp_valid) begin
                            r_kill  <= 1'b0;
                            r_state <= S_REQ;
                        end else begin
                            r_kill <= 1'b1;
                        end
                    end else if (i_imem_resp_valid) begin
                        if (r_kill) begin
                            r_kill  <= 1'b0;
                            r_state <= S_REQ;
                        end else begin
                            r_inst  <= i_imem_resp_data;
                            r_fault <= i_imem_resp_err;
                            r_state <= S_OUT;
                        end
                    end
                end
                S_OUT: begin
                    // A redirect wins over pc+4 even when decode takes the
                    // instruction in the same cycle.
                    if (i_redirect_valid) begin
                        r_pc    <= w_target;
                        r_state <= S_REQ;
                    end else if (i_out_ready) begin
                        r_pc    <= r_pc + 32'd4;
                        r_state <= S_REQ;
                    end
                end
                default: begin
                    r_state <= S_REQ;
                    r_kill  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_25040101_ifu.sv
module tb_ysyx_25040101_ifu;

    localparam logic [31:0] B = 32'h8000_0000;

    logic        clk, rst_n;
    logic        rdy, rv, re, xv, ordy;
    logic [31:0] rd, xpc;
    logic        rqv, ov, oflt;
    logic [31:0] addr, opc, oinst;

    int total = 0;
    int bad   = 0;

    ysyx_25040101_ifu #(.RESET_PC(B)) dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .o_imem_req_valid (rqv),
        .i_imem_req_ready (rdy),
        .o_imem_req_addr  (addr),
        .i_imem_resp_valid(rv),
        .i_imem_resp_data (rd),
        .i_imem_resp_err  (re),
        .i_redirect_valid (xv),
        .i_redirect_pc    (xpc),
        .o_out_valid      (ov),
        .i_out_ready      (ordy),
        .o_out_inst       (oinst),
        .o_out_pc         (opc),
        .o_out_fault      (oflt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents as a function of address, so stale data is recognisable.
    function automatic logic [31:0] fdat(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    function automatic logic ferr(input logic [31:0] a);
        return (a[4:2] == 3'b101);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        rdy, rv;
        logic [31:0] rd;
        logic        re, xv;
        logic [31:0] xpc;
        logic        ordy;
        logic        e_rqv;
        logic [31:0] e_pc;
        logic        e_ov;
        logic [31:0] e_inst;
        logic        e_flt;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic a_rdy, input logic a_rv, input logic [31:0] a_rd,
                       input logic a_re, input logic a_xv, input logic [31:0] a_xpc,
                       input logic a_ordy, input logic a_rqv, input logic [31:0] a_pc,
                       input logic a_ov, input logic [31:0] a_inst, input logic a_flt);
        vec_t v;
        v.rdy = a_rdy; v.rv = a_rv; v.rd = a_rd; v.re = a_re; v.xv = a_xv;
        v.xpc = a_xpc; v.ordy = a_ordy; v.e_rqv = a_rqv; v.e_pc = a_pc;
        v.e_ov = a_ov; v.e_inst = a_inst; v.e_flt = a_flt;
        tbl.push_back(v);
    endtask

    // Random-phase reference model state
    logic [31:0] m_pc;
    bit          m_hold, m_outst, m_keep, nxt_hold, e_rqv;
    int          lat, delivered;
    logic [31:0] r32;

    initial begin
        rst_n = 1'b0; rdy = 0; rv = 0; re = 0; xv = 0; ordy = 0; rd = 0; xpc = 0;

        // zero-wait fetches, decode stall, fault, redirects, wrap
        add(1,0,0,0,0,0,1,            1,B,0,0,0);
        add(1,1,fdat(B),0,0,0,1,      0,B,0,0,0);
        add(1,0,0,0,0,0,1,            0,B,1,fdat(B),0);
        add(1,0,0,0,0,0,1,            1,B+4,0,fdat(B),0);
        add(1,1,fdat(B+4),0,0,0,1,    0,B+4,0,fdat(B),0);
        for (int i = 0; i < 5; i++)
            add(1,0,0,0,0,0,0,        0,B+4,1,fdat(B+4),0);
        add(1,0,0,0,0,0,1,            0,B+4,1,fdat(B+4),0);
        add(1,0,0,0,0,0,1,            1,B+8,0,fdat(B+4),0);
        add(1,1,fdat(B+8),1,0,0,1,    0,B+8,0,fdat(B+4),0);
        add(1,0,0,0,0,0,1,            0,B+8,1,fdat(B+8),1);
        add(1,0,0,0,0,0,1,            1,B+12,0,fdat(B+8),1);
        add(1,1,fdat(B+12),0,0,0,1,   0,B+12,0,fdat(B+8),1);
        add(1,0,0,0,0,0,1,            0,B+12,1,fdat(B+12),0);
        add(1,0,0,0,0,0,1,            1,B+16,0,fdat(B+12),0);
        add(1,0,0,0,1,32'h8000_1002,1, 0,B+16,0,fdat(B+12),0);
        add(1,0,0,0,0,0,0,            0,B+32'h1000,0,fdat(B+12),0);
        add(1,0,0,0,0,0,0,            0,B+32'h1000,0,fdat(B+12),0);
        add(1,1,fdat(B+16),0,0,0,1,   0,B+32'h1000,0,fdat(B+12),0);
        add(1,0,0,0,0,0,1,            1,B+32'h1000,0,fdat(B+12),0);
        add(1,1,fdat(B+32'h1000),0,1,32'h8000_2000,1, 0,B+32'h1000,0,fdat(B+12),0);
        add(1,0,0,0,0,0,1,            1,B+32'h2000,0,fdat(B+12),0);
        add(1,1,fdat(B+32'h2000),0,0,0,1, 0,B+32'h2000,0,fdat(B+12),0);
        add(1,0,0,0,1,32'h8000_3000,1, 0,B+32'h2000,1,fdat(B+32'h2000),0);
        add(1,0,0,0,1,32'h8000_4001,1, 0,B+32'h3000,0,fdat(B+32'h2000),0);
        add(0,0,0,0,0,0,1,            1,B+32'h4000,0,fdat(B+32'h2000),0);
        add(1,0,0,0,0,0,1,            1,B+32'h4000,0,fdat(B+32'h2000),0);
        add(1,1,fdat(B+32'h4000),0,0,0,1, 0,B+32'h4000,0,fdat(B+32'h2000),0);
        add(1,0,0,0,0,0,1,            0,B+32'h4000,1,fdat(B+32'h4000),0);
        add(0,0,0,0,0,0,1,            1,B+32'h4004,0,fdat(B+32'h4000),0);
        add(0,0,0,0,1,32'hFFFF_FFFF,0, 0,B+32'h4004,0,fdat(B+32'h4000),0);
        add(1,0,0,0,0,0,0,            1,32'hFFFF_FFFC,0,fdat(B+32'h4000),0);
        add(1,1,fdat(32'hFFFF_FFFC),0,0,0,1, 0,32'hFFFF_FFFC,0,fdat(B+32'h4000),0);
        add(1,0,0,0,0,0,1,            0,32'hFFFF_FFFC,1,fdat(32'hFFFF_FFFC),0);
        add(1,0,0,0,0,0,1,            1,32'h0,0,fdat(32'hFFFF_FFFC),0);

        // reset state
        #12;
        chk("rst_req_valid", {31'b0, rqv}, 32'h0);
        chk("rst_out_valid", {31'b0, ov}, 32'h0);
        chk("rst_out_pc", opc, B);
        chk("rst_out_inst", oinst, 32'h0);
        chk("rst_out_fault", {31'b0, oflt}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (tbl[i]) begin
            rdy = tbl[i].rdy; rv = tbl[i].rv; rd = tbl[i].rd; re = tbl[i].re;
            xv = tbl[i].xv; xpc = tbl[i].xpc; ordy = tbl[i].ordy;
            @(negedge clk);
            chk($sformatf("v%0d_req_valid", i), {31'b0, rqv}, {31'b0, tbl[i].e_rqv});
            chk($sformatf("v%0d_req_addr", i), addr, tbl[i].e_pc);
            chk($sformatf("v%0d_out_valid", i), {31'b0, ov}, {31'b0, tbl[i].e_ov});
            chk($sformatf("v%0d_out_pc", i), opc, tbl[i].e_pc);
            chk($sformatf("v%0d_out_inst", i), oinst, tbl[i].e_inst);
            chk($sformatf("v%0d_out_fault", i), {31'b0, oflt}, {31'b0, tbl[i].e_flt});
            @(posedge clk); #1;
        end

        // last vector left a request to pc 0 accepted: now in WAIT; reset mid-cycle
        rdy = 0; rv = 0; re = 0; xv = 0; ordy = 0; rd = 0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", {31'b0, ov}, 32'h0);
        chk("arst_req_valid", {31'b0, rqv}, 32'h0);
        chk("arst_pc", opc, B);
        chk("arst_inst", oinst, 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_req_valid", {31'b0, rqv}, 32'h1);
        chk("post_rst_req_addr", addr, B);
        @(posedge clk); #1;

        // randomized traffic against a transaction-level model
        m_pc = B; m_hold = 0; m_outst = 0; m_keep = 0; lat = 0; delivered = 0;
        for (int c = 0; c < 3000; c++) begin
            rdy  = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 2) != 0);
            xv   = ($urandom_range(0, 9) == 0);
            r32  = $urandom();
            xpc  = B | (r32 & 32'h0000_FFFF);
            rv   = 0; rd = $urandom(); re = $urandom_range(0, 1);
            if (m_outst) begin
                if (lat == 0) begin
                    rv = 1; rd = fdat(addr); re = ferr(addr);
                end else begin
                    lat--;
                end
            end
            @(negedge clk);
            e_rqv = !m_hold && !m_outst && !xv;
            chk("rnd_req_valid", {31'b0, rqv}, {31'b0, e_rqv});
            chk("rnd_out_valid", {31'b0, ov}, {31'b0, m_hold});
            if (opc !== m_pc) chk("rnd_pc", opc, m_pc);
            if (rqv && addr !== m_pc) chk("rnd_req_addr", addr, m_pc);
            if (m_hold) begin
                if (oinst !== fdat(m_pc)) chk("rnd_out_inst", oinst, fdat(m_pc));
                if (oflt !== ferr(m_pc)) chk("rnd_out_fault", {31'b0, oflt}, {31'b0, ferr(m_pc)});
            end
            nxt_hold = m_hold;
            if (m_hold && (xv || ordy)) begin
                nxt_hold = 0;
                if (ordy) delivered++;
            end
            if (m_outst) begin
                if (xv) m_keep = 0;
                if (rv) begin
                    m_outst = 0;
                    if (m_keep) nxt_hold = 1;
                end
            end else if (e_rqv && rdy) begin
                m_outst = 1; m_keep = 1; lat = $urandom_range(0, 2);
            end
            if (xv) m_pc = xpc & ~32'h3;
            else if (m_hold && ordy) m_pc = m_pc + 32'd4;
            m_hold = nxt_hold;
            @(posedge clk); #1;
        end
        chk("rnd_progress", {31'b0, delivered > 100}, 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ysyx_25040101_ifu.md
# ysyx_25040101_ifu

Instruction fetch unit for the NPC core. Holds the PC and fetches one 32-bit instruction at a time from instruction memory over a request/response handshake. Presents the instruction and its PC to decode through a valid/ready output. Decode in turn drives the immediate extender and control unit. Accepts redirects (branch/jump/trap targets) from execute at any time and discards any stale fetch.

## Interface
Parameters:
- RESET_PC, 32'h8000_0000, PC value loaded on reset; bits [1:0] must be 00.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request this cycle.
- imem_req_addr  out  32  fetch address; equals current PC.
- imem_resp_valid  in  1  response valid; only legal while a request is outstanding.
- imem_resp_data  in  32  fetched instruction word.
- imem_resp_err  in  1  access fault for this response.
- redirect_valid  in  1  load new PC from execute.
- redirect_pc  in  32  redirect target; bits [1:0] ignored and forced to 00.
- out_valid  out  1  instruction available to decode.
- out_ready  in  1  decode accepts instruction.
- out_inst  out  32  instruction word (inst[31:7] feeds the immediate extender).
- out_pc  out  32  PC of out_inst.
- out_fault  out  1  instruction fetch access fault.

## Operation
- Registers: pc, state, kill, inst_q, fault_q.
- Reset values:
  - pc = RESET_PC; state = REQ; kill = 0.
  - out_valid = 0; out_inst = 32'h0; out_fault = 0; out_pc = RESET_PC.
  - imem_req_valid is 0 while rst_n is low.
- imem_req_valid = (state==REQ) && !redirect_valid; imem_req_addr = pc.
- out_valid = (state==OUT); out_pc = pc; out_inst = inst_q; out_fault = fault_q.
- States and transitions:
  - REQ: on redirect_valid, pc <= {redirect_pc[31:2],2'b00} and stay in REQ. Otherwise, on imem_req_ready, go to WAIT.
  - WAIT, kill=0, no redirect: on imem_resp_valid, inst_q <= data, fault_q <= err, go to OUT.
  - WAIT with redirect_valid: pc <= target. If imem_resp_valid is also high this cycle, drop the response and go to REQ. Otherwise set kill and stay in WAIT.
  - WAIT, kill=1: on imem_resp_valid, drop the response, clear kill, go to REQ. A further redirect here updates pc again and keeps kill set.
  - OUT, no redirect: on out_ready, pc <= pc + 32'd4 (wraps mod 2^32), go to REQ. Otherwise hold all outputs stable.
  - OUT with redirect_valid: pc <= target, go to REQ; the held instruction is discarded. If out_ready is also high, the handshake still counts as consumed, but pc takes the redirect target, not pc+4.
- Priority: redirect > response/handshake > hold.
- At most one request is outstanding. No new request is issued until the response (kept or dropped) has returned.
- A faulting fetch is delivered like a normal one with out_fault=1. Trap handling is decode/execute's job; the IFU does not stop.
- Reset asserted mid-operation aborts everything immediately. After release, fetch restarts in REQ at RESET_PC. A memory response to the aborted request must not arrive after reset; this is an integration requirement on memory.

## Timing
- Zero-wait memory (req_ready=1, resp 1 cycle after acceptance, out_ready=1):
  - Request accepted in cycle t.
  - Response in t+1.
  - out_valid in t+2.
  - Next request in t+3.
  - Throughput: one instruction per 3 cycles.
- imem_resp_valid is never sampled in the same cycle its request is accepted.
- A redirect in cycle t produces imem_req_valid=1 with the new address at t+1 at the earliest (REQ/OUT), or 1 cycle after the stale response returns (WAIT).
- out_* are registered; they are stable while out_valid=1 and out_ready=0.

## Test plan
- Reset release, zero-wait memory returning pc-derived data, out_ready=1 -> addresses 0x80000000, 0x80000004, 0x80000008 issued every 3 cycles; out_pc/out_inst match.
- out_ready held low 5 cycles with out_valid=1 -> outputs unchanged, no new imem request; after ready, next address is pc+4.
- redirect_pc=0x80001002 in WAIT, response 3 cycles later -> that response is not delivered; next request address is 0x80001000.
- Redirect in the same cycle as imem_resp_valid, and separately in the same cycle as the out_ready handshake -> response dropped / instruction consumed once; next request goes to the redirect target, not pc+4.
- imem_resp_err=1 -> out_fault=1 with that PC; the following fetch proceeds to pc+4 with out_fault=0.
- pc=0xFFFFFFFC consumed -> next request at 0x00000000. rst_n pulsed low in WAIT -> out_valid=0 and pc=RESET_PC asynchronously.
